i2s_adc_receiver: RTL and testbench
===================================

Name: i2s_adc_receiver

Overview:
Receive side of the codec digital audio interface. Deserializes the codec ADC serial stream (BCLK, ADC_LR_CLK, ADC_DATA) into parallel left/right signed samples in the system clk domain. Presents each stereo pair to downstream logic (mixer, FFT front end) through a valid/ready handshake. Runs alongside the DAC transmit path and the I2C configuration sequencer; the codec is configured as master for 16-bit I2S.

Parameters:
SAMPLE_WIDTH, 16, bits per channel word captured MSB-first; legal values 8..24.
I2S_DELAY, 1, BCLK periods between an ADC_LR_CLK edge and the word MSB; 1 = I2S, 0 = left-justified.
SYNC_STAGES, 2, flip-flop stages synchronizing BCLK, ADC_LR_CLK and ADC_DATA into clk; legal values 2..3.

Ports:
clk  input  1  system clock; must be at least 8x BCLK frequency.
reset  input  1  asynchronous, active-low reset.
enable  input  1  receiver enable; low forces IDLE and suppresses output.
BCLK  input  1  codec bit clock, asynchronous to clk.
ADC_LR_CLK  input  1  codec frame clock; 0 = left word, 1 = right word.
ADC_DATA  input  1  codec serial ADC data, valid on BCLK rising edge.
left_sample  output  SAMPLE_WIDTH  last complete left word, two's complement.
right_sample  output  SAMPLE_WIDTH  last complete right word, two's complement.
out_valid  output  1  stereo pair available.
out_ready  input  1  downstream accepts pair when high with out_valid.
overflow  output  1  sticky: a pair was overwritten before acceptance.
ovf_clear  input  1  one-cycle pulse clears overflow.
short_word  output  1  one-cycle pulse: word ended before SAMPLE_WIDTH bits were captured.

Behaviour:
- Reset (reset low, async): all outputs 0, shift register 0, bit counter 0, FSM in IDLE.
- BCLK, ADC_LR_CLK and ADC_DATA each pass through SYNC_STAGES flops. A BCLK rising edge is detected when the synchronized BCLK is 1 and was 0 one cycle earlier.
- All FSM activity occurs only on cycles where a BCLK rising edge is detected ("bit tick"). At each tick, sample ADC_DATA and ADC_LR_CLK; lr_prev holds the value from the previous tick.
- Frame edge: a tick where the sampled ADC_LR_CLK differs from lr_prev. The channel for the new word is the new ADC_LR_CLK value.
- FSM:
  - IDLE: wait for a 1->0 frame edge (left word start). Go to SKIP if I2S_DELAY=1, else to SHIFT, capturing the current bit as the MSB.
  - SKIP: consume exactly I2S_DELAY ticks, then go to SHIFT.
  - SHIFT: shift ADC_DATA into the LSB at each tick and increment the counter. When the counter reaches SAMPLE_WIDTH, commit the word and go to WAIT.
  - WAIT: ignore bits until the next frame edge, then restart SKIP or SHIFT for the other channel.
- Frame edge while in SHIFT with counter < SAMPLE_WIDTH:
  - Commit the word left-aligned with the remaining LSBs zero-padded.
  - Pulse short_word for 1 cycle.
  - Start the new word immediately; the edge tick counts as its delay or MSB tick per I2S_DELAY.
- Commit:
  - A left word goes to an internal holding register.
  - A right word, together with the held left word, loads left_sample and right_sample on the next clk cycle, and out_valid is set in the same cycle.
  - A right word without a preceding left word since IDLE is discarded.
- Handshake:
  - out_valid && out_ready in a cycle clears out_valid at the next cycle.
  - The data outputs hold stable while out_valid is high and out_ready is low, except on overwrite.
  - Overwrite: a new pair commits while out_valid=1 and no accept occurs that cycle. The new pair replaces the old one, out_valid stays 1, and overflow is set.
  - Accept and commit in the same cycle: the new pair loads, out_valid stays 1, and no overflow is flagged.
- overflow is cleared by ovf_clear. If a set and ovf_clear occur in the same cycle, the set wins.
- enable low:
  - FSM goes to IDLE, the counter and holding register clear, and no further commits occur.
  - Existing out_valid and output data are retained until accepted.
  - On re-enable, reception resumes at the next left-word start.
- Latency: pin-level BCLK rising edge of the right-word LSB to out_valid high = SYNC_STAGES+2 clk cycles.

Optional Feature:
PEAK_HOLD_EN:
- Defined: adds output peak_level[SAMPLE_WIDTH-1:0] and input peak_clear.
- peak_level tracks the maximum absolute value over both channels of every committed pair. The most negative value saturates to max positive.
- peak_level updates in the same cycle the outputs load.
- peak_clear zeroes peak_level; if a pair commits in the same cycle, the result is that pair's peak.
- Not defined: port and logic absent.

Test Plan:
- I2S, 16-bit, BCLK=clk/16: left 16'h8001, right 16'h7FFE, out_ready=1 -> left_sample=16'h8001, right_sample=16'h7FFE, out_valid high 1 cycle, overflow=0.
- out_ready=0 for two frames (pairs 16'h1111/16'h2222, then 16'h3333/16'h4444) -> outputs 16'h3333/16'h4444, overflow=1; ovf_clear pulse -> overflow=0.
- ADC_LR_CLK toggles after 12 bits of left word 16'hABCx -> left_sample=16'hABC0, short_word pulse once, right word received correctly.
- Reset asserted mid-right-word, then released -> all outputs 0 immediately; first pair reported is the next complete left+right frame.
- enable low during a left word, high two frames later -> no pair output while low; first pair after re-enable matches the transmitted frame.
- PEAK_HOLD_EN defined: pairs 16'h0100/16'hFF00, then 16'h8000/16'h0000 -> peak_level=16'h0100, then 16'h7FFF; peak_clear -> 0.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: codec ADC serial stream (BCLK / ADC_LR_CLK / ADC_DATA)
// to parallel signed left/right samples in the clk domain, handed downstream
// through a valid/ready handshake with sticky overflow reporting.
// Optional build macro PEAK_HOLD_EN adds a peak_level output tracking the
// largest absolute sample value, with a peak_clear input.
module i2s_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int I2S_DELAY    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    BCLK,
  input  logic                    ADC_LR_CLK,
  input  logic                    ADC_DATA,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    ovf_clear,
`ifdef PEAK_HOLD_EN
  output logic [SAMPLE_WIDTH-1:0] peak_level,
  input  logic                    peak_clear,
`endif
  output logic                    short_word
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SHIFT, ST_WAIT} state_t;

  // A new word begins either with a delay tick to skip or directly with its MSB.
  localparam state_t START_ST = (I2S_DELAY != 0) ? ST_SKIP : ST_SHIFT;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  bclk_sync, lr_sync, data_sync;
  logic                    bclk_prev, lr_prev;
  logic                    bclk_s, lr_s, data_s;
  logic                    tick, frame_edge, left_start;
  logic [SAMPLE_WIDTH-1:0] shift_reg, shift_next, commit_word;
  logic [SAMPLE_WIDTH-1:0] hold_left, pend_left, pend_right;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    ch, ch_next, start_word;
  logic                    have_left, pend_valid, commit, short_pulse, accept;

  // Bring the three codec pins into clk and keep last synchronized BCLK for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      data_sync <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], ADC_LR_CLK};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ADC_DATA};
      bclk_prev <= bclk_s;
    end
  end

  assign bclk_s     = bclk_sync[SYNC_STAGES-1];
  assign lr_s       = lr_sync[SYNC_STAGES-1];
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign tick       = bclk_s & ~bclk_prev;
  assign frame_edge = tick & (lr_s ^ lr_prev);
  assign left_start = frame_edge & ~lr_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state: only bit ticks move the machine, enable low parks it in IDLE
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else if (tick) begin
      case (state)
        ST_IDLE:  if (left_start) state_next = START_ST;
        ST_SKIP:  state_next = frame_edge ? START_ST : ST_SHIFT;
        ST_SHIFT: begin
          if (frame_edge)                              state_next = START_ST;
          else if (cnt == CW'(SAMPLE_WIDTH - 1))      state_next = ST_WAIT;
        end
        ST_WAIT:  if (frame_edge) state_next = START_ST;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: shift/count updates, word commits and short-word detection
  always_comb begin
    shift_next  = shift_reg;
    cnt_next    = cnt;
    ch_next     = ch;
    commit      = 1'b0;
    commit_word = '0;
    short_pulse = 1'b0;
    start_word  = 1'b0;
    if (!enable) begin
      shift_next = '0;
      cnt_next   = '0;
    end else if (tick) begin
      case (state)
        ST_IDLE: start_word = left_start;
        ST_SKIP: begin
          if (frame_edge) begin
            start_word = 1'b1;
          end else begin
            shift_next = {{(SAMPLE_WIDTH-1){1'b0}}, data_s};
            cnt_next   = CW'(1);
          end
        end
        ST_SHIFT: begin
          if (frame_edge) begin
            commit      = 1'b1;
            commit_word = shift_reg << (SAMPLE_WIDTH - int'(cnt));
            short_pulse = 1'b1;
            start_word  = 1'b1;
          end else begin
            shift_next = {shift_reg[SAMPLE_WIDTH-2:0], data_s};
            cnt_next   = cnt + CW'(1);
            if (cnt == CW'(SAMPLE_WIDTH - 1)) begin
              commit      = 1'b1;
              commit_word = shift_next;
            end
          end
        end
        ST_WAIT: start_word = frame_edge;
        default: start_word = 1'b0;
      endcase
      if (start_word) begin
        ch_next = lr_s;
        if (I2S_DELAY == 0) begin
          shift_next = {{(SAMPLE_WIDTH-1){1'b0}}, data_s};
          cnt_next   = CW'(1);
        end else begin
          shift_next = '0;
          cnt_next   = '0;
        end
      end
    end
  end

  // Word assembly registers; lr_prev only advances on bit ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      cnt        <= '0;
      ch         <= 1'b0;
      lr_prev    <= 1'b0;
      short_word <= 1'b0;
    end else begin
      shift_reg  <= shift_next;
      cnt        <= cnt_next;
      ch         <= ch_next;
      short_word <= short_pulse;
      if (tick) lr_prev <= lr_s;
    end
  end

  // Left words wait in a holding register; a right word pairs with it for one-cycle staging
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_left  <= '0;
      have_left  <= 1'b0;
      pend_left  <= '0;
      pend_right <= '0;
      pend_valid <= 1'b0;
    end else if (!enable) begin
      hold_left  <= '0;
      have_left  <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (commit) begin
        if (!ch) begin
          hold_left <= commit_word;
          have_left <= 1'b1;
        end else if (have_left) begin
          pend_left  <= hold_left;
          pend_right <= commit_word;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  assign accept = out_valid & out_ready;

  // Downstream handshake: a staged pair always loads, overflow marks an unaccepted overwrite
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_sample  <= '0;
      right_sample <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (pend_valid) begin
        left_sample  <= pend_left;
        right_sample <= pend_right;
        out_valid    <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (pend_valid && out_valid && !accept) overflow <= 1'b1;
      else if (ovf_clear)                     overflow <= 1'b0;
    end
  end

`ifdef PEAK_HOLD_EN
  logic [SAMPLE_WIDTH-1:0] left_abs, right_abs, pair_peak;

  function automatic logic [SAMPLE_WIDTH-1:0] abs_sat(input logic [SAMPLE_WIDTH-1:0] v);
    if (!v[SAMPLE_WIDTH-1])                          return v;
    else if (v == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}) return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else                                             return -v;
  endfunction

  // Magnitude of the pair about to load, most negative value saturating to max positive
  always_comb begin
    left_abs  = abs_sat(pend_left);
    right_abs = abs_sat(pend_right);
    pair_peak = (left_abs > right_abs) ? left_abs : right_abs;
  end

  // Peak follows the loaded pairs; a clear coinciding with a load restarts from that pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_level <= '0;
    end else if (pend_valid) begin
      if (peak_clear || pair_peak > peak_level) peak_level <= pair_peak;
    end else if (peak_clear) begin
      peak_level <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Testbench for i2s_adc_receiver: drives an I2S codec stream with random and
// directed frames and checks the delivered pairs against a frame-level model.
module tb_i2s_adc_receiver;

  localparam int W = 16;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          enable     = 1'b0;
  logic          BCLK       = 1'b0;
  logic          ADC_LR_CLK = 1'b1;
  logic          ADC_DATA   = 1'b0;
  logic          out_ready  = 1'b1;
  logic          ovf_clear  = 1'b0;
  logic [W-1:0]  left_sample, right_sample;
  logic          out_valid, overflow, short_word;
`ifdef PEAK_HOLD_EN
  logic [W-1:0]  peak_level;
  logic          peak_clear = 1'b0;
  logic [15:0]   expPeak    = 16'h0000;
`endif

  int            checks     = 0;
  int            errors     = 0;
  int            shortSeen  = 0;
  int            shortExp   = 0;
  int            extraPairs = 0;
  logic [31:0]   expQ[$];
  logic          expOvf     = 1'b0;

  always #5 clk = ~clk;

  i2s_adc_receiver #(
    .SAMPLE_WIDTH(W),
    .I2S_DELAY(1),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .BCLK(BCLK),
    .ADC_LR_CLK(ADC_LR_CLK),
    .ADC_DATA(ADC_DATA),
    .left_sample(left_sample),
    .right_sample(right_sample),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .ovf_clear(ovf_clear),
`ifdef PEAK_HOLD_EN
    .peak_level(peak_level),
    .peak_clear(peak_clear),
`endif
    .short_word(short_word)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

`ifdef PEAK_HOLD_EN
  function automatic logic [15:0] absSat(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction
`endif

  // Frame-level model: an unaccepted pending pair is replaced by the next one and flags overflow
  task automatic pushPair(input logic [15:0] l, input logic [15:0] r);
    if (expQ.size() > 0 && !out_ready) begin
      expQ[expQ.size()-1] = {l, r};
      expOvf = 1'b1;
    end else begin
      expQ.push_back({l, r});
    end
`ifdef PEAK_HOLD_EN
    if (absSat(l) > expPeak) expPeak = absSat(l);
    if (absSat(r) > expPeak) expPeak = absSat(r);
`endif
  endtask

  // Every accepted pair must match the oldest expected pair
  always @(negedge clk) begin
    logic [31:0] p;
    if (reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        extraPairs++;
      end else begin
        p = expQ.pop_front();
        checkOutput("pair_left", 32'(left_sample), 32'(p[31:16]));
        checkOutput("pair_right", 32'(right_sample), 32'(p[15:0]));
      end
    end
    if (short_word) shortSeen++;
  end

  // One BCLK period: data and frame clock change on the falling edge
  task automatic sendBit(input logic lr, input logic d);
    ADC_LR_CLK = lr;
    ADC_DATA   = d;
    #80 BCLK = 1'b1;
    #80 BCLK = 0;
  endtask

  // One I2S frame; evKind 1 drops enable at left bit evBit, evKind 2 pulses reset at right bit evBit
  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int lbits,
                               input int evKind, input int evBit, input bit chkLat);
    logic [15:0] mask;
    bit          willPair;
    mask     = 16'hFFFF;
    mask     = mask << (16 - lbits);
    willPair = enable && (evKind == 0);
    sendBit(1'b0, 1'($urandom));
    for (int i = 0; i < lbits; i++) begin
      if (evKind == 1 && i == evBit) enable = 1'b0;
      sendBit(1'b0, l[15-i]);
    end
    if (lbits < 16) begin
      if (enable) shortExp++;
    end else begin
      repeat ($urandom_range(0, 2)) sendBit(1'b0, 1'($urandom));
    end
    if (willPair) pushPair(l & mask, r);
    sendBit(1'b1, 1'($urandom));
    for (int i = 0; i < 16; i++) begin
      if (evKind == 2 && i == evBit) begin
        reset = 1'b0;
        #1;
        checkOutput("rst_left", 32'(left_sample), 32'h0);
        checkOutput("rst_right", 32'(right_sample), 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_overflow", 32'(overflow), 32'h0);
        expOvf = 1'b0;
        #19 reset = 1'b1;
      end
      if (chkLat && i == 15) begin
        ADC_LR_CLK = 1'b1;
        ADC_DATA   = r[0];
        #80 BCLK = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkOutput("latency_early", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1 checkOutput("latency_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1 checkOutput("valid_one_cycle", 32'(out_valid), 32'h0);
        #32 BCLK = 1'b0;
      end else begin
        sendBit(1'b1, r[15-i]);
      end
    end
    sendBit(1'b1, 1'($urandom));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int          lb;
    logic [15:0] rl, rr;

    #3;
    checkOutput("reset_left", 32'(left_sample), 32'h0);
    checkOutput("reset_right", 32'(right_sample), 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);
    checkOutput("reset_short", 32'(short_word), 32'h0);
    #20 reset = 1'b1;
    enable = 1'b1;
    repeat (3) sendBit(1'b1, 1'($urandom));

    $display("[TB] basic pair with latency check");
    applyStimulus(16'h8001, 16'h7FFE, 16, 0, 0, 1'b1);
    checkOutput("basic_overflow", 32'(overflow), 32'h0);

    $display("[TB] overwrite with out_ready low");
    out_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 16, 0, 0, 1'b0);
    applyStimulus(16'h3333, 16'h4444, 16, 0, 0, 1'b0);
    #100;
    checkOutput("ovw_left", 32'(left_sample), 32'h3333);
    checkOutput("ovw_right", 32'(right_sample), 32'h4444);
    checkOutput("ovw_valid", 32'(out_valid), 32'h1);
    checkOutput("ovw_overflow", 32'(overflow), 32'(expOvf));
    ovf_clear = 1'b1;
    #10 ovf_clear = 1'b0;
    expOvf = 1'b0;
    #10 checkOutput("ovf_cleared", 32'(overflow), 32'(expOvf));
    out_ready = 1'b1;
    #20;

    $display("[TB] short left word");
    rl = 16'($urandom);
    applyStimulus({12'hABC, rl[3:0]}, 16'($urandom), 12, 0, 0, 1'b0);

    $display("[TB] reset mid right word");
    applyStimulus(16'($urandom), 16'($urandom), 16, 2, 7, 1'b0);
    applyStimulus(16'($urandom), 16'($urandom), 16, 0, 0, 1'b0);

    $display("[TB] enable dropped during left word");
    applyStimulus(16'($urandom), 16'($urandom), 16, 1, 5, 1'b0);
    applyStimulus(16'($urandom), 16'($urandom), 16, 0, 0, 1'b0);
    applyStimulus(16'($urandom), 16'($urandom), 16, 0, 0, 1'b0);
    checkOutput("disabled_no_pending", 32'(expQ.size()), 32'h0);
    enable = 1'b1;
    applyStimulus(16'($urandom), 16'($urandom), 16, 0, 0, 1'b0);

`ifdef PEAK_HOLD_EN
    $display("[TB] peak hold");
    peak_clear = 1'b1;
    #10 peak_clear = 1'b0;
    expPeak = 16'h0000;
    #10 checkOutput("peak_cleared_start", 32'(peak_level), 32'(expPeak));
    applyStimulus(16'h0100, 16'hFF00, 16, 0, 0, 1'b0);
    checkOutput("peak_first", 32'(peak_level), 32'(expPeak));
    applyStimulus(16'h8000, 16'h0000, 16, 0, 0, 1'b0);
    checkOutput("peak_saturated", 32'(peak_level), 32'(expPeak));
    peak_clear = 1'b1;
    #10 peak_clear = 1'b0;
    expPeak = 16'h0000;
    #10 checkOutput("peak_cleared", 32'(peak_level), 32'(expPeak));
`endif

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      out_ready = 1'($urandom);
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : 16;
      rl = 16'($urandom);
      rr = 16'($urandom);
      applyStimulus(rl, rr, lb, 0, 0, 1'b0);
    end
    checkOutput("random_overflow", 32'(overflow), 32'(expOvf));
    out_ready = 1'b1;
    #200;

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    checkOutput("extra_pairs", 32'(extraPairs), 32'h0);
    checkOutput("short_count", 32'(shortSeen), 32'(shortExp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
